operand_select_mux: RTL and testbench



---
 rtl/operand_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/operand_select_mux.sv | 110 +++++++++++
 tb/tb_operand_select_mux.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_mux_pkg.sv
// Shared constants and the select-width helper for the operand select mux.
package operand_mux_pkg;

    localparam int OPERAND_MUX_MAX_CHANNELS = 16;

    function automatic int sel_width(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: round-robin from ptr when OPERAND_SELECT_MUX_RR_EN
// is defined, otherwise a lowest-index-wins priority encoder (ptr ignored).
module rr_arbiter
    import operand_mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic found;

`ifdef OPERAND_SELECT_MUX_RR_EN
    logic [SEL_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Walk the channels starting at ptr, wrapping at CHANNELS.
        for (int k = 0; k < CHANNELS; k++) begin
            cand = SEL_W'((int'(ptr) + k) % CHANNELS);
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (en && !found && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = SEL_W'(k);
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/operand_select_mux.sv
// Registered N:1 operand mux with valid/ready on every channel and the output.
// Arbitration is round-robin when OPERAND_SELECT_MUX_RR_EN is defined, fixed priority otherwise.
module operand_select_mux
    import operand_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_sel_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q,    out_data_d;
    logic [SEL_W-1:0]    out_channel_q, out_channel_d;
    logic                out_valid_q,   out_valid_d;

    logic [CHANNELS-1:0] arb_grant, grant;
    logic [SEL_W-1:0]    arb_idx, grant_idx;
    logic [SEL_W-1:0]    rr_ptr;
    logic                load, accept;

`ifdef OPERAND_SELECT_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .en        (~force_sel_en),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Manual override; an out-of-range index grants nothing.
    always_comb begin
        grant     = arb_grant;
        grant_idx = arb_idx;
        if (force_sel_en) begin
            grant     = '0;
            grant_idx = force_sel;
            if (int'(force_sel) < CHANNELS) begin
                grant[force_sel] = in_valid[force_sel];
            end
        end
    end

    assign load     = ~out_valid_q | out_ready;
    assign in_ready = grant & {CHANNELS{load}};
    assign accept   = |in_ready;

    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        if (accept) begin
            out_data_d    = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_channel_d = grant_idx;
            out_valid_d   = 1'b1;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
        end
    end

`ifdef OPERAND_SELECT_MUX_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && !force_sel_en) begin
            rr_ptr_d = (arb_idx == SEL_W'(CHANNELS-1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_operand_select_mux.sv
// Directed bench for operand_select_mux: main 8x4 instance plus 16-bit sweeps at 1 and 16 channels.
module tb_operand_select_mux;

    logic clk;
    logic rst_n;

    logic [31:0]  m_in_data;
    logic [3:0]   m_in_valid, m_in_ready;
    logic         m_fen;
    logic [1:0]   m_fsel;
    logic [7:0]   m_out_data;
    logic [1:0]   m_out_ch;
    logic         m_out_valid, m_out_ready;

    logic [255:0] s_in_data;
    logic [15:0]  s_in_valid, s_in_ready;
    logic         s_fen;
    logic [3:0]   s_fsel;
    logic [15:0]  s_out_data;
    logic [3:0]   s_out_ch;
    logic         s_out_valid, s_out_ready;

    logic [15:0]  o_in_data;
    logic [0:0]   o_in_valid, o_in_ready;
    logic         o_fen;
    logic [0:0]   o_fsel;
    logic [15:0]  o_out_data;
    logic [0:0]   o_out_ch;
    logic         o_out_valid, o_out_ready;

    int compared;
    int mismatched;

    operand_select_mux #(.WIDTH(8), .CHANNELS(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .force_sel_en(m_fen), .force_sel(m_fsel),
        .out_data(m_out_data), .out_channel(m_out_ch), .out_valid(m_out_valid),
        .out_ready(m_out_ready)
    );

    operand_select_mux #(.WIDTH(16), .CHANNELS(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .force_sel_en(s_fen), .force_sel(s_fsel),
        .out_data(s_out_data), .out_channel(s_out_ch), .out_valid(s_out_valid),
        .out_ready(s_out_ready)
    );

    operand_select_mux #(.WIDTH(16), .CHANNELS(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_data(o_in_data), .in_valid(o_in_valid),
        .in_ready(o_in_ready), .force_sel_en(o_fen), .force_sel(o_fsel),
        .out_data(o_out_data), .out_channel(o_out_ch), .out_valid(o_out_valid),
        .out_ready(o_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_in_data   = $urandom;
            m_in_valid  = 4'($urandom_range(0, 15));
            m_fen       = 1'($urandom_range(0, 1));
            m_fsel      = 2'($urandom_range(0, 3));
            m_out_ready = 1'($urandom_range(0, 1));
            #1;
            compared++;
            if (m_out_valid !== 1'b0 || m_out_data !== 8'h00 || m_out_ch !== 2'd0) begin
                mismatched++;
                $display("FAIL reset_hold: valid=%b data=%h ch=%0d, required 0/00/0",
                         m_out_valid, m_out_data, m_out_ch);
            end
        end
        @(negedge clk);
        m_in_valid  = 4'b0000;
        m_fen       = 1'b0;
        m_fsel      = 2'd0;
        m_out_ready = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            compared++;
            if (m_out_valid !== 1'b0 || m_out_data !== 8'h00 || m_out_ch !== 2'd0 ||
                m_in_ready !== 4'b0000) begin
                mismatched++;
                $display("FAIL reset_idle: valid=%b data=%h ch=%0d in_ready=%b, required 0/00/0/0000",
                         m_out_valid, m_out_data, m_out_ch, m_in_ready);
            end
        end
    endtask

    task automatic test_manual;
        logic [1:0] sel_vec [2];
        logic [7:0] dat_vec [2];
        sel_vec[0] = 2'd0; dat_vec[0] = 8'h00;
        sel_vec[1] = 2'd1; dat_vec[1] = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m_fen       = 1'b1;
            m_fsel      = sel_vec[i];
            m_in_data   = {8'h00, 8'h00, 8'hFF, 8'h00};
            m_in_valid  = 4'b0011;
            m_out_ready = 1'b1;
            #1;
            compared++;
            if (m_in_ready !== (4'b0001 << sel_vec[i])) begin
                mismatched++;
                $display("FAIL manual_ready sel=%0d: in_ready=%b, required %b",
                         sel_vec[i], m_in_ready, 4'b0001 << sel_vec[i]);
            end
            @(posedge clk);
            #1;
            compared++;
            if (m_out_valid !== 1'b1 || m_out_data !== dat_vec[i] || m_out_ch !== sel_vec[i]) begin
                mismatched++;
                $display("FAIL manual_out sel=%0d: valid=%b data=%h ch=%0d, required 1/%h/%0d",
                         sel_vec[i], m_out_valid, m_out_data, m_out_ch, dat_vec[i], sel_vec[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        int seq [5];
`ifdef OPERAND_SELECT_MUX_RR_EN
        seq = '{0, 1, 2, 3, 0};
`else
        seq = '{0, 0, 0, 0, 0};
`endif
        @(negedge clk);
        m_fen       = 1'b0;
        m_in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        m_in_valid  = 4'b1111;
        m_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++;
            if (m_in_ready !== (4'b0001 << seq[i])) begin
                mismatched++;
                $display("FAIL arb_ready step %0d: in_ready=%b, required %b",
                         i, m_in_ready, 4'b0001 << seq[i]);
            end
            @(posedge clk);
            #1;
            compared++;
            if (m_out_valid !== 1'b1 || m_out_ch !== 2'(seq[i]) || m_out_data !== 8'(8'h10 + seq[i])) begin
                mismatched++;
                $display("FAIL arb_out step %0d: valid=%b ch=%0d data=%h, required 1/%0d/%h",
                         i, m_out_valid, m_out_ch, m_out_data, seq[i], 8'(8'h10 + seq[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        m_fen       = 1'b0;
        m_in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        m_in_valid  = 4'b0100;
        m_out_ready = 1'b1;
        #1;
        compared++;
        if (m_in_ready !== 4'b0100) begin
            mismatched++;
            $display("FAIL bp_load_ready: in_ready=%b, required 0100", m_in_ready);
        end
        @(negedge clk);
        m_in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        m_in_valid  = 4'b1111;
        m_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++;
            if (m_in_ready !== 4'b0000 || m_out_valid !== 1'b1 || m_out_data !== 8'hA5 ||
                m_out_ch !== 2'd2) begin
                mismatched++;
                $display("FAIL bp_hold cycle %0d: in_ready=%b valid=%b data=%h ch=%0d, required 0000/1/a5/2",
                         i, m_in_ready, m_out_valid, m_out_data, m_out_ch);
            end
            @(negedge clk);
        end
        m_in_data   = {8'h3C, 8'h00, 8'h00, 8'h00};
        m_in_valid  = 4'b1000;
        m_out_ready = 1'b1;
        #1;
        compared++;
        if (m_in_ready !== 4'b1000) begin
            mismatched++;
            $display("FAIL bp_release_ready: in_ready=%b, required 1000", m_in_ready);
        end
        @(posedge clk);
        #1;
        compared++;
        if (m_out_valid !== 1'b1 || m_out_data !== 8'h3C || m_out_ch !== 2'd3) begin
            mismatched++;
            $display("FAIL bp_release_out: valid=%b data=%h ch=%0d, required 1/3c/3",
                     m_out_valid, m_out_data, m_out_ch);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        m_fen       = 1'b0;
        m_in_data   = {8'h00, 8'h00, 8'h7E, 8'h00};
        m_in_valid  = 4'b0010;
        m_out_ready = 1'b1;
        @(negedge clk);
        m_in_valid  = 4'b0000;
        m_out_ready = 1'b0;
        #1;
        compared++;
        if (m_out_valid !== 1'b1 || m_out_data !== 8'h7E || m_out_ch !== 2'd1) begin
            mismatched++;
            $display("FAIL rst_mid_pre: valid=%b data=%h ch=%0d, required 1/7e/1",
                     m_out_valid, m_out_data, m_out_ch);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if (m_out_valid !== 1'b0 || m_out_data !== 8'h00 || m_out_ch !== 2'd0) begin
            mismatched++;
            $display("FAIL rst_mid_async: valid=%b data=%h ch=%0d, required 0/00/0",
                     m_out_valid, m_out_data, m_out_ch);
        end
        #1 rst_n = 1'b1;
        m_in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        m_in_valid  = 4'b1111;
        m_out_ready = 1'b1;
        #1;
        compared++;
        if (m_in_ready !== 4'b0001) begin
            mismatched++;
            $display("FAIL rst_mid_ptr: in_ready=%b, required 0001", m_in_ready);
        end
        @(posedge clk);
        #1;
        compared++;
        if (m_out_valid !== 1'b1 || m_out_ch !== 2'd0 || m_out_data !== 8'h10) begin
            mismatched++;
            $display("FAIL rst_mid_first: valid=%b ch=%0d data=%h, required 1/0/10",
                     m_out_valid, m_out_ch, m_out_data);
        end
        @(negedge clk);
        m_in_valid = 4'b0000;
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        o_fen       = 1'b1;
        o_fsel      = 1'b0;
        o_in_data   = 16'h1234;
        o_in_valid  = 1'b1;
        o_out_ready = 1'b1;
        #1;
        compared++;
        if (o_in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_in_range_ready: in_ready=%b, required 1", o_in_ready);
        end
        @(negedge clk);
        o_fsel    = 1'b1;
        o_in_data = 16'h5678;
        #1;
        compared++;
        if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== 16'h1234 || o_out_ch !== 1'b0) begin
            mismatched++;
            $display("FAIL oor_block: in_ready=%b valid=%b data=%h ch=%0d, required 0/1/1234/0",
                     o_in_ready, o_out_valid, o_out_data, o_out_ch);
        end
        @(negedge clk);
        #1;
        compared++;
        if (o_out_valid !== 1'b0 || o_out_data !== 16'h1234 || o_in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL oor_drain: valid=%b data=%h in_ready=%b, required 0/1234/0",
                     o_out_valid, o_out_data, o_in_ready);
        end
        o_in_valid = 1'b0;
        o_fen      = 1'b0;
    endtask

    task automatic test_sweep;
        int sent16 [16];
        int recv16 [16];
        int sent1, recv1, ch;
        logic [15:0] exp16;
        logic        load1, exp_rdy1;
        for (int c = 0; c < 16; c++) begin
            sent16[c] = 0;
            recv16[c] = 0;
        end
        sent1 = 0;
        recv1 = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                s_in_valid[c]          = (cyc < 400) && ($urandom_range(0, 2) != 0);
                s_in_data[c*16 +: 16]  = {8'(c), 8'(sent16[c])};
            end
            s_out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
            s_fen       = (cyc < 400) && ($urandom_range(0, 7) == 0);
            s_fsel      = 4'($urandom_range(0, 15));
            o_in_valid  = 1'((cyc < 400) && ($urandom_range(0, 2) != 0));
            o_in_data   = 16'(sent1);
            o_out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
            o_fen       = (cyc < 400) && ($urandom_range(0, 3) == 0);
            o_fsel      = 1'($urandom_range(0, 1));
            #1;
            compared++;
            if ($countones(s_in_ready) > 1 || (s_in_ready & ~s_in_valid) != 16'h0 ||
                (s_out_valid && !s_out_ready && s_in_ready != 16'h0) ||
                (!s_fen && (!s_out_valid || s_out_ready) && s_in_valid != 16'h0 && s_in_ready == 16'h0)) begin
                mismatched++;
                $display("FAIL sweep16_ready cyc %0d: in_ready=%h valid=%h fen=%b ov=%b or=%b",
                         cyc, s_in_ready, s_in_valid, s_fen, s_out_valid, s_out_ready);
            end
            if (s_out_valid && s_out_ready) begin
                ch    = int'(s_out_ch);
                exp16 = {8'(ch), 8'(recv16[ch])};
                compared++;
                if (s_out_data !== exp16 || recv16[ch] >= sent16[ch]) begin
                    mismatched++;
                    $display("FAIL sweep16_word cyc %0d ch %0d: data=%h, required %h (recv %0d sent %0d)",
                             cyc, ch, s_out_data, exp16, recv16[ch], sent16[ch]);
                end
                recv16[ch]++;
            end
            for (int c = 0; c < 16; c++) begin
                if (s_in_ready[c]) sent16[c]++;
            end
            load1    = !o_out_valid || o_out_ready;
            exp_rdy1 = o_in_valid[0] && load1 && (!o_fen || o_fsel == 1'b0);
            compared++;
            if (o_in_ready[0] !== exp_rdy1 || o_out_ch !== 1'b0) begin
                mismatched++;
                $display("FAIL sweep1_ready cyc %0d: in_ready=%b ch=%0d, required %b/0",
                         cyc, o_in_ready, o_out_ch, exp_rdy1);
            end
            if (o_out_valid && o_out_ready) begin
                compared++;
                if (o_out_data !== 16'(recv1) || recv1 >= sent1) begin
                    mismatched++;
                    $display("FAIL sweep1_word cyc %0d: data=%h, required %h (recv %0d sent %0d)",
                             cyc, o_out_data, 16'(recv1), recv1, sent1);
                end
                recv1++;
            end
            if (o_in_ready[0]) sent1++;
        end
        for (int c = 0; c < 16; c++) begin
            compared++;
            if (recv16[c] != sent16[c]) begin
                mismatched++;
                $display("FAIL sweep16_count ch %0d: delivered %0d, required %0d", c, recv16[c], sent16[c]);
            end
        end
        compared++;
        if (recv1 != sent1 || sent1 == 0) begin
            mismatched++;
            $display("FAIL sweep1_count: delivered %0d, required %0d (nonzero)", recv1, sent1);
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        m_in_data   = '0; m_in_valid = '0; m_fen = 1'b0; m_fsel = '0; m_out_ready = 1'b0;
        s_in_data   = '0; s_in_valid = '0; s_fen = 1'b0; s_fsel = '0; s_out_ready = 1'b0;
        o_in_data   = '0; o_in_valid = '0; o_fen = 1'b0; o_fsel = '0; o_out_ready = 1'b0;
        test_reset();
        test_manual();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_out_of_range();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
